// File: rtl/frame_mem_if.sv
// Bus bundle between the CPU port, the VGA pixel fetcher, the shared RAM and the arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface frame_mem_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WIDTH-1:0]  cpu_wdata;
  logic [WIDTH-1:0]  cpu_rdata;
  logic              cpu_ready;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [WIDTH-1:0]  vga_rdata;
  logic              vga_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_rdata, cpu_ready, vga_rdata, vga_valid, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_rdata, cpu_ready, vga_rdata, vga_valid, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Shares one single-port frame RAM between the CPU and the VGA fetcher, VGA first.
// Define FMA_STARVE_GUARD_EN to let a CPU that has waited MAX_WAIT cycles win over VGA.
module frame_mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  frame_mem_if.slave    bus
);

  typedef enum logic {IDLE, CPU_ACK} state_t;

  if ((2 ** ADDR_W) < DEPTH || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_param_err
    $error("frame_mem_arbiter: bad ADDR_W/DEPTH/MAX_WAIT combination");
  end

  state_t            state_q, state_d;
  logic              gnt_vga_q, gnt_vga_d;
  logic              gnt_cpu_rd_q, gnt_cpu_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic              mem_we_c;
  logic              guard_trip;
  logic              vga_win;
  logic              cpu_win;

  // Nothing is granted while reset is held, so the RAM never sees a stray write.
  assign vga_win = !rst && bus.vga_req && !guard_trip;
  assign cpu_win = !rst && !vga_win && bus.cpu_req && (state_q == IDLE);

`ifdef FMA_STARVE_GUARD_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign guard_trip = (state_q == IDLE) && bus.cpu_req && (wait_cnt_q == 8'(MAX_WAIT));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.cpu_req || cpu_win) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == IDLE && wait_cnt_q != 8'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign guard_trip = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    gnt_vga_d    = 1'b0;
    gnt_cpu_rd_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_c     = 1'b0;

    if (vga_win) begin
      mem_addr_d = bus.vga_addr;
      gnt_vga_d  = 1'b1;
    end else if (cpu_win) begin
      mem_addr_d   = bus.cpu_addr;
      mem_wdata_d  = bus.cpu_wdata;
      mem_we_c     = bus.cpu_we;
      gnt_cpu_rd_d = !bus.cpu_we;
    end

    case (state_q)
      IDLE:    if (cpu_win) state_d = CPU_ACK;
      CPU_ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data is captured only in the cycle after a CPU read grant, held otherwise.
    cpu_rdata_d = gnt_cpu_rd_q ? bus.mem_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_vga_q    <= 1'b0;
      gnt_cpu_rd_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_vga_q    <= gnt_vga_d;
      gnt_cpu_rd_q <= gnt_cpu_rd_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.mem_we    = mem_we_c;
  assign bus.cpu_ready = (state_q == CPU_ACK);
  assign bus.cpu_rdata = cpu_rdata_d;
  assign bus.vga_valid = gnt_vga_q;
  assign bus.vga_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a behavioural single-port RAM (addr^0xA5 preload).
// Expectations switch on FMA_STARVE_GUARD_EN to match the build.
module tb_frame_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic ram_init;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  frame_mem_if #(.WIDTH(32), .ADDR_W(8)) bus ();

  frame_mem_arbiter #(.WIDTH(32), .DEPTH(256), .ADDR_W(8), .MAX_WAIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [0:255];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'(i) ^ 32'h0000_00A5;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    logic        vr;
    logic [7:0]  va;
    logic        cr;
    logic        cw;
    logic [7:0]  ca;
    logic [31:0] cd;
    logic        e_we;
    logic [7:0]  e_addr;
    logic        e_rdy;
    logic        e_vv;
    logic [31:0] e_vd;
    logic [31:0] e_cd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] pre(input int a);
    return 32'(a) ^ 32'h0000_00A5;
  endfunction

  function automatic vec_t mk(input logic vr, input int va, input logic cr, input logic cw,
                              input int ca, input logic [31:0] cd, input logic e_we,
                              input int e_addr, input logic e_rdy, input logic e_vv,
                              input logic [31:0] e_vd, input logic [31:0] e_cd);
    vec_t v;
    v.vr = vr; v.va = 8'(va); v.cr = cr; v.cw = cw; v.ca = 8'(ca); v.cd = cd;
    v.e_we = e_we; v.e_addr = 8'(e_addr); v.e_rdy = e_rdy; v.e_vv = e_vv;
    v.e_vd = e_vd; v.e_cd = e_cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vr, input logic [7:0] va, input logic cr, input logic cw,
                       input logic [7:0] ca, input logic [31:0] cd);
    @(posedge clk);
    #1;
    bus.vga_req = vr; bus.vga_addr = va;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
  endtask

  task automatic check_cycle(input string tag, input logic e_we, input logic [7:0] e_addr,
                             input logic e_rdy, input logic e_vv, input logic [31:0] e_vd,
                             input logic [31:0] e_cd);
    @(negedge clk);
    chk({tag, " mem_we"},    32'(bus.mem_we),    32'(e_we));
    chk({tag, " mem_addr"},  32'(bus.mem_addr),  32'(e_addr));
    chk({tag, " cpu_ready"}, 32'(bus.cpu_ready), 32'(e_rdy));
    chk({tag, " vga_valid"}, 32'(bus.vga_valid), 32'(e_vv));
    chk({tag, " cpu_rdata"}, bus.cpu_rdata,      e_cd);
    if (e_vv) chk({tag, " vga_rdata"}, bus.vga_rdata, e_vd);
    $display("%s: we=%0b addr=%h rdy=%0b vv=%0b vdata=%h cdata=%h", tag, bus.mem_we,
             bus.mem_addr, bus.cpu_ready, bus.vga_valid, bus.vga_rdata, bus.cpu_rdata);
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, " mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, " mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, " mem_wdata"}, bus.mem_wdata,      32'd0);
    chk({tag, " cpu_ready"}, 32'(bus.cpu_ready), 32'd0);
    chk({tag, " vga_valid"}, 32'(bus.vga_valid), 32'd0);
    chk({tag, " cpu_rdata"}, bus.cpu_rdata,      32'd0);
    $display("%s: in reset, we=%0b addr=%h rdy=%0b vv=%0b", tag, bus.mem_we, bus.mem_addr,
             bus.cpu_ready, bus.vga_valid);
  endtask

  initial begin
    logic        g_cpu;
    logic [31:0] cdata;

    // Reset with both requesters active: nothing may reach the RAM.
    rst = 1'b1; ram_init = 1'b1;
    bus.vga_req = 1'b1; bus.vga_addr = 8'h33;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h44; bus.cpu_wdata = 32'h1111_2222;
    bus.mem_rdata = '0;
    check_reset("reset c0");
    check_reset("reset c1");
    @(posedge clk);
    #1;
    rst = 1'b0; ram_init = 1'b0;
    bus.vga_req = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;

    // VGA burst over 0x00..0x1F, one word per cycle.
    for (int i = 0; i < 32; i++)
      vecs.push_back(mk(1, i, 0, 0, 0, 0, 0, i, 0, i != 0, (i != 0) ? pre(i - 1) : 32'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h1F, 0, 1, pre('h1F), 0));
    // CPU write then read back of 0x10, then VGA reads the new word.
    vecs.push_back(mk(0, 0, 1, 1, 'h10, 32'hDEADBEEF, 1, 'h10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h10, 0, 0, 'h10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h10, 1, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 'h10, 0, 0, 0, 0, 0, 'h10, 0, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h10, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF));
    // Simultaneous requests: VGA first, CPU next cycle, request held through ready.
    vecs.push_back(mk(1, 'h05, 1, 0, 'h20, 0, 0, 'h05, 0, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 1, 0, 'h20, 0, 0, 'h20, 0, 1, pre('h05), 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 1, 0, 'h20, 0, 0, 'h20, 1, 0, 0, pre('h20)));
    vecs.push_back(mk(0, 0, 1, 0, 'h20, 0, 0, 'h20, 0, 0, 0, pre('h20)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h20, 1, 0, 0, pre('h20)));
    // VGA granted in the CPU_ACK cycle.
    vecs.push_back(mk(0, 0, 1, 0, 'h21, 0, 0, 'h21, 0, 0, 0, pre('h20)));
    vecs.push_back(mk(1, 'h03, 0, 0, 0, 0, 0, 'h03, 1, 0, 0, pre('h21)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h03, 0, 1, pre('h03), pre('h21)));
    // CPU write dropped before grant is never served.
    vecs.push_back(mk(1, 'h04, 1, 1, 'h22, 32'h123, 0, 'h04, 0, 0, 0, pre('h21)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h04, 0, 1, pre('h04), pre('h21)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h04, 0, 0, 0, pre('h21)));
    vecs.push_back(mk(0, 0, 1, 0, 'h22, 0, 0, 'h22, 0, 0, 0, pre('h21)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h22, 1, 0, 0, pre('h22)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h22, 0, 0, 0, pre('h22)));

    foreach (vecs[k]) begin
      drive(vecs[k].vr, vecs[k].va, vecs[k].cr, vecs[k].cw, vecs[k].ca, vecs[k].cd);
      check_cycle($sformatf("vec %0d", k), vecs[k].e_we, vecs[k].e_addr, vecs[k].e_rdy,
                  vecs[k].e_vv, vecs[k].e_vd, vecs[k].e_cd);
    end

    // Continuous VGA with a held CPU read of 0x40.
    for (int c = 0; c < 100; c++) begin
`ifdef FMA_STARVE_GUARD_EN
      g_cpu = (c == 15);
      cdata = (c >= 16) ? pre('h40) : pre('h22);
      drive(1'b1, 8'(8'h80 + c), c < 16, 1'b0, 8'h40, 32'd0);
      check_cycle($sformatf("starve %0d", c), 1'b0, g_cpu ? 8'h40 : 8'(8'h80 + c), c == 16,
                  (c > 0) && (c != 16), pre(8'h80 + c - 1), cdata);
`else
      g_cpu = 1'b0;
      cdata = pre('h22);
      drive(1'b1, 8'(8'h80 + c), 1'b1, 1'b0, 8'h40, 32'd0);
      check_cycle($sformatf("starve %0d", c), 1'b0, 8'(8'h80 + c), g_cpu, c > 0,
                  pre(8'h80 + c - 1), cdata);
`endif
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd0);

    // Reset mid-operation: pending vga_valid and cpu_ready are lost.
    drive(1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 32'hCAFEF00D);
    check_cycle("pre-rst write", 1'b1, 8'h30, 1'b0, 1'b1, pre('h07), cdata);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.vga_req = 1'b1; bus.vga_addr = 8'h09;
    check_reset("mid rst c0");
    check_reset("mid rst c1");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.vga_req = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 32'd0);
    check_cycle("post-rst read", 1'b0, 8'h30, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd0);
    check_cycle("post-rst ready", 1'b0, 8'h30, 1'b1, 1'b0, 32'd0, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
